control_unit_fsm: RTL and testbench

//  Instruction decoder and run sequencer driving Datapath_Module's control inputs.

---
 rtl/control_unit_fsm.sv | 184 ++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_fsm.sv
// Instruction decoder and LOAD/CLEAR/RUN/HALT sequencer for the datapath.
// Owns the NZCV register, branch evaluation and the retired counter.
module control_unit_fsm #(
  parameter int OPW   = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [15:0]      mem_instr_out,
  input  logic             Pre_C,
  input  logic             Pre_V,
  input  logic             Pre_Z,
  input  logic             Pre_N,
  output logic             test_normal,
  output logic             dp_clr,
  output logic             flag_HLT,
  output logic             ADC,
  output logic             SUB,
  output logic             SBB,
  output logic             JMP,
  output logic             BRANCH,
  output logic             Src_ALU_B,
  output logic             Src_Read_B,
  output logic             flag_label_PC,
  output logic             flag_Rm_PC,
  output logic             flag_Rd_PC,
  output logic             flag_mem_RF,
  output logic             flag_ALU_RF,
  output logic             flag_Rm_RF,
  output logic             flag_PC_RF,
  output logic             RF_write_en,
  output logic             data_write_en,
  output logic             LHI,
  output logic             LLI,
  output logic             flag_OutR,
  output logic [3:0]       flags_nzcv,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {LOAD, CLEAR, RUN, HALT} state_t;

  localparam logic [OPW-1:0] OP_ALU  = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LLI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_LHI  = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_LDR  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_STR  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_SUBI = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_BR0  = OPW'(5'b11000);
  localparam logic [OPW-1:0] OP_BR1  = OPW'(5'b11001);
  localparam logic [OPW-1:0] OP_OUTR = OPW'(5'b11100);
  localparam logic [OPW-1:0] OP_HLT  = OPW'(5'b11111);

  state_t         state;
  logic [OPW-1:0] op;
  logic [3:0]     cond;
  logic [1:0]     func;
  logic           take;
  logic           legal;
  logic           is_hlt;
  logic           upd_flags;
  logic           n, z, c, v;
  logic           unused;

  assign op     = mem_instr_out[15 -: OPW];
  assign cond   = mem_instr_out[11:8];
  assign func   = mem_instr_out[1:0];
  assign unused = ^mem_instr_out[7:2];
  assign {n, z, c, v} = flags_nzcv;

  assign test_normal = (state == LOAD);
  assign dp_clr      = (state == CLEAR);
  assign flag_HLT    = (state == RUN);
  assign halted      = (state == HALT);

  // Branches see the registered flags only; no bypass from Pre_*.
  always_comb begin
    take = 1'b0;
    unique case (cond)
      4'h0: take = z;
      4'h1: take = !z;
      4'h2: take = c;
      4'h3: take = !c;
      4'h4: take = n;
      4'h5: take = !n;
      4'h6: take = v;
      4'h7: take = !v;
      4'h8: take = c && !z;
      4'h9: take = !c || z;
      4'hA: take = (n == v);
      4'hB: take = (n != v);
      4'hC: take = !z && (n == v);
      4'hD: take = z || (n != v);
      4'hE: take = 1'b1;
      4'hF: take = 1'b0;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    ADC = 1'b0; SUB = 1'b0; SBB = 1'b0;
    JMP = 1'b0; BRANCH = 1'b0;
    Src_ALU_B = 1'b0; Src_Read_B = 1'b0;
    flag_label_PC = 1'b0; flag_Rm_PC = 1'b0; flag_Rd_PC = 1'b0;
    flag_mem_RF = 1'b0; flag_ALU_RF = 1'b0;
    flag_Rm_RF = 1'b0; flag_PC_RF = 1'b0;
    RF_write_en = 1'b0; data_write_en = 1'b0;
    LHI = 1'b0; LLI = 1'b0; flag_OutR = 1'b0;
    legal = 1'b1; is_hlt = 1'b0; upd_flags = 1'b0;
    if (state == RUN) begin
      unique case (op)
        OP_ALU: begin
          ADC = (func == 2'b01);
          SUB = (func == 2'b10);
          SBB = (func == 2'b11);
          flag_ALU_RF = 1'b1; RF_write_en = 1'b1;
          upd_flags = 1'b1;
        end
        OP_LLI: begin
          LLI = 1'b1; RF_write_en = 1'b1;
        end
        OP_LHI: begin
          LHI = 1'b1; Src_Read_B = 1'b1; RF_write_en = 1'b1;
        end
        OP_LDR: begin
          Src_ALU_B = 1'b1; flag_mem_RF = 1'b1; RF_write_en = 1'b1;
        end
        OP_STR: begin
          Src_ALU_B = 1'b1; Src_Read_B = 1'b1; data_write_en = 1'b1;
        end
        OP_ADDI: begin
          Src_ALU_B = 1'b1; flag_ALU_RF = 1'b1; RF_write_en = 1'b1;
          upd_flags = 1'b1;
        end
        OP_SUBI: begin
          Src_ALU_B = 1'b1; SUB = 1'b1;
          flag_ALU_RF = 1'b1; RF_write_en = 1'b1;
          upd_flags = 1'b1;
        end
        OP_JMP: begin
          JMP = 1'b1; flag_label_PC = 1'b1;
        end
        OP_JAL: begin
          BRANCH = 1'b1; flag_PC_RF = 1'b1; RF_write_en = 1'b1;
        end
        OP_BR0, OP_BR1: BRANCH = take;
        OP_OUTR: flag_OutR = 1'b1;
        OP_HLT: is_hlt = 1'b1;
        default: legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= LOAD;
      flags_nzcv <= 4'h0;
      illegal    <= 1'b0;
      retired    <= '0;
    end else begin
      unique case (state)
        LOAD:  if (start) state <= CLEAR;
        CLEAR: state <= RUN;
        RUN: begin
          if (is_hlt) begin
            state <= HALT;
          end else begin
            if (~&retired) retired <= retired + CNT_W'(1);
            if (upd_flags) flags_nzcv <= {Pre_N, Pre_Z, Pre_C, Pre_V};
            if (!legal) illegal <= 1'b1;
          end
        end
        HALT:    state <= HALT;
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Bench for control_unit_fsm: spec-level model checked every cycle,
// plus directed vectors with literal expectations.
module tb_control_unit_fsm;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [15:0] mem_instr_out;
  logic        Pre_C, Pre_V, Pre_Z, Pre_N;
  logic        test_normal, dp_clr, flag_HLT;
  logic        ADC, SUB, SBB, JMP, BRANCH, Src_ALU_B, Src_Read_B;
  logic        flag_label_PC, flag_Rm_PC, flag_Rd_PC;
  logic        flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF;
  logic        RF_write_en, data_write_en, LHI, LLI, flag_OutR;
  logic [3:0]  flags_nzcv;
  logic        halted, illegal;
  logic [15:0] retired;

  always #5 clk = ~clk;

  control_unit_fsm #(.OPW(5), .CNT_W(16)) dut (
    .clk(clk), .clr(clr), .start(start), .mem_instr_out(mem_instr_out),
    .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z), .Pre_N(Pre_N),
    .test_normal(test_normal), .dp_clr(dp_clr), .flag_HLT(flag_HLT),
    .ADC(ADC), .SUB(SUB), .SBB(SBB), .JMP(JMP), .BRANCH(BRANCH),
    .Src_ALU_B(Src_ALU_B), .Src_Read_B(Src_Read_B),
    .flag_label_PC(flag_label_PC), .flag_Rm_PC(flag_Rm_PC),
    .flag_Rd_PC(flag_Rd_PC), .flag_mem_RF(flag_mem_RF),
    .flag_ALU_RF(flag_ALU_RF), .flag_Rm_RF(flag_Rm_RF),
    .flag_PC_RF(flag_PC_RF), .RF_write_en(RF_write_en),
    .data_write_en(data_write_en), .LHI(LHI), .LLI(LLI),
    .flag_OutR(flag_OutR), .flags_nzcv(flags_nzcv), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  localparam int B_ADC = 18, B_SUB = 17, B_SBB = 16, B_JMP = 15;
  localparam int B_BR = 14, B_SAB = 13, B_SRB = 12, B_LPC = 11;
  localparam int B_MEM = 8, B_ALU = 7, B_PCRF = 5;
  localparam int B_WE = 4, B_DWE = 3, B_LHI = 2, B_LLI = 1, B_OUT = 0;

  logic [18:0] act_str;
  assign act_str = {ADC, SUB, SBB, JMP, BRANCH, Src_ALU_B, Src_Read_B,
                    flag_label_PC, flag_Rm_PC, flag_Rd_PC, flag_mem_RF,
                    flag_ALU_RF, flag_Rm_RF, flag_PC_RF, RF_write_en,
                    data_write_en, LHI, LLI, flag_OutR};

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 LOAD, 1 CLEAR, 2 RUN, 3 HALT
  int         m_phase = 0;
  logic [3:0] m_flags = 4'h0;
  bit         m_ill   = 1'b0;
  int         m_ret   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic bit cond_ok(input logic [3:0] cd, input logic [3:0] f);
    bit nn, zz, cc, vv;
    {nn, zz, cc, vv} = f;
    case (cd)
      4'h0: return zz;
      4'h1: return !zz;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return nn;
      4'h5: return !nn;
      4'h6: return vv;
      4'h7: return !vv;
      4'h8: return cc && !zz;
      4'h9: return !cc || zz;
      4'hA: return nn == vv;
      4'hB: return nn != vv;
      4'hC: return !zz && (nn == vv);
      4'hD: return zz || (nn != vv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [4:0] o);
    return o inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd7, 5'd8,
                     5'd16, 5'd17, 5'd24, 5'd25, 5'd28, 5'd31};
  endfunction

  function automatic logic [18:0] exp_str(input int ph,
                                          input logic [15:0] ins,
                                          input logic [3:0] f);
    logic [18:0] s;
    s = '0;
    if (ph != 2) return s;
    case (ins[15:11])
      5'd0: begin
        s[B_ALU] = 1; s[B_WE] = 1;
        if (ins[1:0] == 2'd1) s[B_ADC] = 1;
        if (ins[1:0] == 2'd2) s[B_SUB] = 1;
        if (ins[1:0] == 2'd3) s[B_SBB] = 1;
      end
      5'd1: begin s[B_LLI] = 1; s[B_WE] = 1; end
      5'd2: begin s[B_LHI] = 1; s[B_SRB] = 1; s[B_WE] = 1; end
      5'd3: begin s[B_SAB] = 1; s[B_MEM] = 1; s[B_WE] = 1; end
      5'd5: begin s[B_SAB] = 1; s[B_SRB] = 1; s[B_DWE] = 1; end
      5'd7: begin s[B_SAB] = 1; s[B_ALU] = 1; s[B_WE] = 1; end
      5'd8: begin
        s[B_SAB] = 1; s[B_SUB] = 1; s[B_ALU] = 1; s[B_WE] = 1;
      end
      5'd16: begin s[B_JMP] = 1; s[B_LPC] = 1; end
      5'd17: begin s[B_BR] = 1; s[B_PCRF] = 1; s[B_WE] = 1; end
      5'd24, 5'd25: s[B_BR] = cond_ok(ins[11:8], f);
      5'd28: s[B_OUT] = 1;
      default: ;
    endcase
    return s;
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_phase <= 0; m_flags <= 4'h0; m_ill <= 1'b0; m_ret <= 0;
    end else begin
      case (m_phase)
        0: if (start) m_phase <= 1;
        1: m_phase <= 2;
        2: begin
          if (mem_instr_out[15:11] == 5'd31) begin
            m_phase <= 3;
          end else begin
            m_ret <= (m_ret >= 65535) ? 65535 : m_ret + 1;
            if (mem_instr_out[15:11] inside {5'd0, 5'd7, 5'd8})
              m_flags <= {Pre_N, Pre_Z, Pre_C, Pre_V};
            if (!is_legal(mem_instr_out[15:11])) m_ill <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_test_normal", test_normal, m_phase == 0);
      chk("m_dp_clr", dp_clr, m_phase == 1);
      chk("m_flag_HLT", flag_HLT, m_phase == 2);
      chk("m_halted", halted, m_phase == 3);
      chk("m_flags", flags_nzcv, m_flags);
      chk("m_illegal", illegal, m_ill);
      chk("m_retired", retired, m_ret);
      chk("m_strobes", act_str, exp_str(m_phase, mem_instr_out, m_flags));
    end
  end

  task automatic cyc(input logic c, input logic s, input logic [15:0] i,
                     input logic [3:0] pre);
    @(posedge clk);
    #1;
    clr = c; start = s; mem_instr_out = i;
    {Pre_N, Pre_Z, Pre_C, Pre_V} = pre;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; mem_instr_out = 16'h0;
    {Pre_N, Pre_Z, Pre_C, Pre_V} = 4'h0;
    cyc(1, 0, 16'h0000, 4'h0);
    chk_en = 1'b1;
    cyc(1, 0, 16'h0000, 4'h0);
    chk("rst_tn", test_normal, 1);
    chk("rst_ret", retired, 0);
    chk("rst_flags", flags_nzcv, 0);
    chk("rst_ill", illegal, 0);
    cyc(0, 1, 16'h0000, 4'h0);
    chk("load_tn", test_normal, 1);
    chk("load_dpclr", dp_clr, 0);
    cyc(0, 0, 16'h1900, 4'h0);
    chk("clear_dpclr", dp_clr, 1);
    chk("clear_hlt", flag_HLT, 0);
    chk("clear_str", act_str, 0);
    cyc(0, 0, 16'h1900, 4'h0);
    chk("run_hlt", flag_HLT, 1);
    chk("run_dpclr", dp_clr, 0);
    chk("ldr", act_str, 19'h02110);
    cyc(0, 0, 16'h8A07, 4'h0);
    chk("jal", act_str, 19'h04030);
    cyc(0, 0, 16'h0006, 4'b0110);
    chk("sub_ctl", {ADC, SUB, SBB}, 3'b010);
    cyc(0, 0, 16'hC007, 4'h0);
    chk("eq_taken", BRANCH, 1);
    chk("flags_sub", flags_nzcv, 4'b0110);
    cyc(0, 0, 16'h0006, 4'h0);
    cyc(0, 0, 16'hC007, 4'h0);
    chk("eq_not", BRANCH, 0);
    cyc(0, 0, 16'hCE07, 4'h0);
    chk("al", BRANCH, 1);
    cyc(0, 0, 16'h0004, 4'h0);
    chk("add_ctl", {ADC, SUB, SBB}, 3'b000);
    cyc(0, 0, 16'h0005, 4'h0);
    chk("adc_ctl", {ADC, SUB, SBB}, 3'b100);
    cyc(0, 0, 16'h0006, 4'h0);
    chk("sub2_ctl", {ADC, SUB, SBB}, 3'b010);
    cyc(0, 0, 16'h0007, 4'h0);
    chk("sbb_ctl", {ADC, SUB, SBB}, 3'b001);
    cyc(0, 0, 16'h0000, 4'b1001);
    cyc(0, 0, 16'hCA07, 4'h0);
    chk("ge", BRANCH, 1);
    cyc(0, 0, 16'hCB07, 4'h0);
    chk("lt", BRANCH, 0);
    cyc(0, 0, 16'hCC07, 4'h0);
    chk("gt", BRANCH, 1);
    cyc(0, 0, 16'hF000, 4'h0);
    chk("ill_pre", illegal, 0);
    cyc(0, 1, 16'h0800, 4'h0);
    chk("ill_set", illegal, 1);
    chk("lli", act_str, 19'h00012);
    cyc(0, 0, 16'h1900, 4'h0);
    chk("ill_sticky", illegal, 1);
    cyc(1, 0, 16'h1900, 4'h0);
    cyc(0, 0, 16'h1900, 4'h0);
    chk("clr_tn", test_normal, 1);
    chk("clr_ret", retired, 0);
    chk("clr_ill", illegal, 0);
    chk("clr_flags", flags_nzcv, 0);
    chk("clr_str", act_str, 0);
    cyc(0, 1, 16'h0000, 4'h0);
    cyc(0, 0, 16'h0000, 4'h0);
    cyc(0, 0, 16'h0800, 4'h0);
    cyc(0, 0, 16'h1900, 4'h0);
    cyc(0, 0, 16'hE000, 4'h0);
    chk("outr", act_str, 19'h00001);
    cyc(0, 0, 16'hF800, 4'h0);
    cyc(0, 1, 16'hF800, 4'h0);
    chk("halt_h", halted, 1);
    chk("halt_hlt", flag_HLT, 0);
    chk("halt_ret", retired, 3);
    chk("halt_str", act_str, 0);
    cyc(0, 0, 16'h0000, 4'h0);
    chk("halt_stay", halted, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
